dram_cmd_gen: RTL and testbench

- Downstream of the 16-entry request queue. Consumes one dequeued memory request at a time and decodes its 33-bit address into bank group, bank, row and column.
- Tracks open rows for all 16 banks using an open-page policy.
- Emits the DRAM command sequence (PRE/ACT/RD/WR) with tRP, tRCD and burst spacing enforced by cycle counters.

---
 rtl/dram_cmd_gen_if.sv | 30 +++
 rtl/dram_cmd_gen.sv | 213 +++++++++++++++++++++
 tb/tb_dram_cmd_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dram_cmd_gen_if.sv
// Request/command bundle between the request queue, the command generator
// and the DRAM PHY side. The master drives requests; the slave issues commands.
interface dram_cmd_gen_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_opcode;
    logic [32:0] req_addr;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [14:0] cmd_row;
    logic [10:0] cmd_col;
    logic        err;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] conflict_count;

    modport master (
        output req_valid, req_opcode, req_addr,
        input  req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col,
        input  err, hit_count, miss_count, conflict_count
    );

    modport slave (
        input  req_valid, req_opcode, req_addr,
        output req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col,
        output err, hit_count, miss_count, conflict_count
    );
endinterface

// File: rtl/dram_cmd_gen.sv
// DRAM command generator: decodes one request at a time, tracks open rows
// for 16 banks (open-page policy) and issues PRE/ACT/RD/WR with tRP, tRCD
// and burst spacing enforced by a single wait counter.
module dram_cmd_gen #(
    parameter int unsigned T_RP    = 39,
    parameter int unsigned T_RCD   = 39,
    parameter int unsigned T_BURST = 8
) (
    input logic           clk,
    input logic           rst,
    dram_cmd_gen_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_BURST, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_PRE = 3'd2, CMD_RD = 3'd3, CMD_WR = 3'd4
    } cmd_t;

    localparam logic [15:0] RP_LOAD    = 16'(T_RP - 1);
    localparam logic [15:0] RCD_LOAD   = 16'(T_RCD - 1);
    localparam logic [15:0] BURST_LOAD = 16'(T_BURST - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  bg_q, bg_d, bank_q, bank_d;
    logic [14:0] row_q, row_d;
    logic [10:0] col_q, col_d;
    logic [31:0] hit_q, hit_d, miss_q, miss_d, conf_q, conf_d;
    logic [15:0] open_q;
    logic [14:0] row_tab_q [16];

    logic        ready_q, ready_d, cmd_valid_q, cmd_valid_d, err_q, err_d;
    cmd_t        cmd_q, cmd_d;
    logic [1:0]  out_bg_q, out_bg_d, out_bank_q, out_bank_d;
    logic [14:0] out_row_q, out_row_d;
    logic [10:0] out_col_q, out_col_d;

    logic [1:0]  dec_bg, dec_bank;
    logic [14:0] dec_row;
    logic [10:0] dec_col;
    logic [3:0]  dec_idx;
    logic        accept;
    logic        unused_addr_bits;

    assign dec_bg           = bus.req_addr[7:6];
    assign dec_bank         = bus.req_addr[9:8];
    assign dec_row          = bus.req_addr[32:18];
    assign dec_col          = {bus.req_addr[17:10], bus.req_addr[5:3]};
    assign dec_idx          = {dec_bg, dec_bank};
    assign unused_addr_bits = ^bus.req_addr[2:0];
    assign accept           = (state_q == S_IDLE) && bus.req_valid;

    // Next-state, request latch, classification counters and registered-output next values.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        op_d    = op_q;
        bg_d    = bg_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        conf_d  = conf_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = bus.req_opcode;
                    bg_d   = dec_bg;
                    bank_d = dec_bank;
                    row_d  = dec_row;
                    col_d  = dec_col;
                    if (bus.req_opcode == 2'd3) begin
                        state_d = S_ERR;
                    end else if (!open_q[dec_idx]) begin
                        state_d = S_ACT;
                        miss_d  = miss_q + 32'd1;
                    end else if (row_tab_q[dec_idx] == dec_row) begin
                        state_d = S_RW;
                        hit_d   = hit_q + 32'd1;
                    end else begin
                        state_d = S_PRE;
                        conf_d  = conf_q + 32'd1;
                    end
                end
            end
            S_PRE: begin
                if (T_RP > 1) begin
                    state_d = S_WAIT_RP;
                    wait_d  = RP_LOAD;
                end else begin
                    state_d = S_ACT;
                end
            end
            S_WAIT_RP: begin
                if (wait_q == 16'd1) state_d = S_ACT;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_ACT: begin
                if (T_RCD > 1) begin
                    state_d = S_WAIT_RCD;
                    wait_d  = RCD_LOAD;
                end else begin
                    state_d = S_RW;
                end
            end
            S_WAIT_RCD: begin
                if (wait_q == 16'd1) state_d = S_RW;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_RW: begin
                if (T_BURST > 1) begin
                    state_d = S_WAIT_BURST;
                    wait_d  = BURST_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_BURST: begin
                if (wait_q == 16'd1) state_d = S_IDLE;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so a command appears
        // in the same cycle its issuing state is occupied.
        cmd_d = CMD_NOP;
        unique case (state_d)
            S_PRE:   cmd_d = CMD_PRE;
            S_ACT:   cmd_d = CMD_ACT;
            S_RW:    cmd_d = (op_d == 2'd1) ? CMD_WR : CMD_RD;
            default: cmd_d = CMD_NOP;
        endcase
        cmd_valid_d = (cmd_d != CMD_NOP);
        err_d       = (state_d == S_ERR);
        ready_d     = (state_d == S_IDLE);
        out_bg_d    = cmd_valid_d ? bg_d   : out_bg_q;
        out_bank_d  = cmd_valid_d ? bank_d : out_bank_q;
        out_row_d   = cmd_valid_d ? row_d  : out_row_q;
        out_col_d   = cmd_valid_d ? col_d  : out_col_q;
    end

    // State, latched request, counters, open bits and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            op_q        <= '0;
            bg_q        <= '0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            conf_q      <= '0;
            open_q      <= '0;
            ready_q     <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            err_q       <= 1'b0;
            out_bg_q    <= '0;
            out_bank_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            op_q        <= op_d;
            bg_q        <= bg_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            conf_q      <= conf_d;
            ready_q     <= ready_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            err_q       <= err_d;
            out_bg_q    <= out_bg_d;
            out_bank_q  <= out_bank_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            if (state_q == S_PRE) open_q[{bg_q, bank_q}] <= 1'b0;
            if (state_q == S_ACT) open_q[{bg_q, bank_q}] <= 1'b1;
        end
    end

    // Open-row table contents; validity is carried by open_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_ACT) row_tab_q[{bg_q, bank_q}] <= row_q;
    end

    assign bus.req_ready      = ready_q;
    assign bus.cmd_valid      = cmd_valid_q;
    assign bus.cmd            = cmd_q;
    assign bus.cmd_bg         = out_bg_q;
    assign bus.cmd_bank       = out_bank_q;
    assign bus.cmd_row        = out_row_q;
    assign bus.cmd_col        = out_col_q;
    assign bus.err            = err_q;
    assign bus.hit_count      = hit_q;
    assign bus.miss_count     = miss_q;
    assign bus.conflict_count = conf_q;

endmodule

// File: tb/tb_dram_cmd_gen.sv
// Testbench for dram_cmd_gen: directed scenarios plus randomized requests,
// each checked cycle by cycle against a schedule computed from the
// open-page timing rules by a table-based reference model.
module tb_dram_cmd_gen;

    localparam int unsigned TRP    = 39;
    localparam int unsigned TRCD   = 39;
    localparam int unsigned TBURST = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dram_cmd_gen_if bus();

    dram_cmd_gen #(.T_RP(TRP), .T_RCD(TRCD), .T_BURST(TBURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit          m_open [16];
    int unsigned m_row  [16];
    int unsigned m_hit, m_miss, m_conf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
        end
        m_hit  = 0;
        m_miss = 0;
        m_conf = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_status"}, {58'd0, bus.req_ready, bus.err, bus.cmd_valid, bus.cmd}, 64'h20);
        check({tag, "_fields"}, {34'd0, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col}, 64'd0);
        check({tag, "_hit"},  64'(bus.hit_count),      64'd0);
        check({tag, "_miss"}, 64'(bus.miss_count),     64'd0);
        check({tag, "_conf"}, 64'(bus.conflict_count), 64'd0);
    endtask

    // Called right after a negedge; returns right after a negedge.
    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_reset_state("reset");
    endtask

    // Issue one request and check every cycle until req_ready returns.
    // abort_at != 0 pulses reset at that offset after acceptance.
    task automatic run_req(input logic [1:0] op, input logic [14:0] row, input logic [1:0] bg,
                           input logic [1:0] bank, input logic [7:0] colhi, input logic [2:0] collo,
                           input logic [2:0] junk, input int unsigned abort_at);
        int unsigned idx, t_pre, t_act, t_rw, t_err, t_ready, exp_cmd;
        logic [10:0] col;
        idx   = int'(bg) * 4 + int'(bank);
        col   = 11'(int'(colhi) * 8 + int'(collo));
        t_pre = 0; t_act = 0; t_rw = 0; t_err = 0;
        if (op == 2'd3) begin
            t_err = 1; t_ready = 2;
        end else begin
            if (!m_open[idx]) begin
                t_act = 1; t_rw = 1 + TRCD; m_miss++;
            end else if (m_row[idx] == int'(row)) begin
                t_rw = 1; m_hit++;
            end else begin
                t_pre = 1; t_act = 1 + TRP; t_rw = t_act + TRCD; m_conf++;
            end
            t_ready = t_rw + TBURST;
        end

        check("ready_before", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_addr   = {row, colhi, bank, bg, collo, junk};
        @(posedge clk);
        @(negedge clk);

        for (int unsigned k = 1; k <= t_ready; k++) begin
            if (k == t_pre)      exp_cmd = 2;
            else if (k == t_act) exp_cmd = 1;
            else if (k == t_rw)  exp_cmd = (op == 2'd1) ? 4 : 3;
            else                 exp_cmd = 0;
            check("status", {58'd0, bus.req_ready, bus.err, bus.cmd_valid, bus.cmd},
                  {58'd0, k == t_ready, k == t_err, exp_cmd != 0, 3'(exp_cmd)});
            if (exp_cmd != 0)
                check("fields", {34'd0, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col},
                      {34'd0, bg, bank, row, col});
            if (k == 1) begin
                check("hit_count",  64'(bus.hit_count),      64'(m_hit));
                check("miss_count", 64'(bus.miss_count),     64'(m_miss));
                check("conf_count", 64'(bus.conflict_count), 64'(m_conf));
            end
            if (abort_at != 0 && k == abort_at) begin
                do_reset();
                for (int j = 0; j < 60; j++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("after_abort", {58'd0, bus.req_ready, bus.err, bus.cmd_valid, bus.cmd}, 64'h20);
                end
                return;
            end
            if (k == t_ready) break;
            // Garbage on the request inputs while busy must be ignored.
            bus.req_valid  = 1'($urandom_range(1));
            bus.req_opcode = 2'($urandom_range(3));
            bus.req_addr   = 33'({$urandom(), $urandom()});
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;

        if (op != 2'd3) begin
            m_open[idx] = 1'b1;
            m_row[idx]  = int'(row);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_addr   = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("init");

        // Miss, hit, conflict on bank 0.
        run_req(2'd0, 15'd1, 2'd0, 2'd0, 8'd0, 3'd0, 3'd0, 0);
        run_req(2'd0, 15'd1, 2'd0, 2'd0, 8'd1, 3'd1, 3'd0, 0);
        run_req(2'd0, 15'd2, 2'd0, 2'd0, 8'd0, 3'd0, 3'd0, 0);

        // Write miss on bg3 bank0, then illegal opcode.
        do_reset();
        run_req(2'd1, 15'd0, 2'd3, 2'd0, 8'd0, 3'd0, 3'd0, 0);
        run_req(2'd3, 15'd7, 2'd1, 2'd2, 8'd5, 3'd2, 3'd7, 0);
        check("err_hit",  64'(bus.hit_count),      64'(m_hit));
        check("err_miss", 64'(bus.miss_count),     64'(m_miss));
        check("err_conf", 64'(bus.conflict_count), 64'(m_conf));

        // Reset between ACT and RD; re-request must be a miss again.
        do_reset();
        run_req(2'd0, 15'd1, 2'd0, 2'd0, 8'd0, 3'd0, 3'd0, 20);
        run_req(2'd0, 15'd1, 2'd0, 2'd0, 8'd0, 3'd0, 3'd0, 0);

        // Randomized traffic over a few banks and rows to mix all three cases.
        for (int n = 0; n < 30; n++) begin
            run_req(2'($urandom_range(3)), 15'($urandom_range(2)),
                    2'($urandom_range(1)), 2'($urandom_range(1)),
                    8'($urandom_range(255)), 3'($urandom_range(7)),
                    3'($urandom_range(7)), 0);
        end

        // Idle cycles: nothing issued, ready held.
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle", {58'd0, bus.req_ready, bus.err, bus.cmd_valid, bus.cmd}, 64'h20);
        end
        check("final_hit",  64'(bus.hit_count),      64'(m_hit));
        check("final_miss", 64'(bus.miss_count),     64'(m_miss));
        check("final_conf", 64'(bus.conflict_count), 64'(m_conf));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
